// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its neighbours
// (decode/issue and writeback use RF_XLEN as their common data width).
//   rf_state_e : top-level state, SWEEP (post-reset zeroing) or RUN
//   rf_aw()    : address width for a given register count
package regfile_pkg;

  localparam int RF_XLEN = 32;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between issue/writeback (master) and the register file (slave).
//   rd_addr/rd_data/rd_busy : NRD read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   wr_en/wr_addr/wr_data   : NWR write ports
//   iss_valid/iss_rd        : mark a destination register busy
//   ready                   : 1 once the post-reset zeroing sweep is done
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = rf_aw(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/regfile_sb.sv
// Per-register busy scoreboard.
//   iss_valid_i/iss_rd_i : set busy[iss_rd] (x0 ignored)
//   wr_en_i/wr_addr_i    : clear busy of every written register
//   rd_addr_i/rd_busy_o  : NRD combinational lookups; with BYPASS a same-cycle
//                          write to the looked-up register reads as not busy
// Callers must gate wr_en_i/iss_valid_i while the file is not in RUN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW-1:0]    look_addr;
  logic             look_hit;

  // Clears first, then the issue: an issue and a write to the same register
  // in one cycle leave it busy, because the issued instruction is the newer
  // producer.
  // NOTE: every variable written in an always_comb gets a value at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
        busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_valid_i && (iss_rd_i != '0)) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its pre-edge inputs regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    look_addr = '0;
    look_hit  = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      look_addr = rd_addr_i[i*AW +: AW];
      look_hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == look_addr)) begin
          look_hit = 1'b1;
        end
      end
      rd_busy_o[i] = busy_q[look_addr] & ~((BYPASS != 0) && look_hit);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with hardwired x0,
// optional write->read bypass, busy scoreboard and post-reset zeroing sweep.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : regfile_mp_if slave port (reads, writes, issues, ready)
// After reset the file spends NREGS-1 cycles writing zero into x1..xN-1;
// writes and issues are ignored and reads return 0/not-busy until ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_aw(NREGS);

  rf_state_e           state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                run;
  logic [NWR-1:0]      wr_en_run;
  logic                iss_run;
  logic [NRD-1:0]      sb_busy;
  logic [NRD*XLEN-1:0] rd_data_c;
  logic [AW-1:0]       rd_a;
  logic [XLEN-1:0]     rd_word;

  // x0 is never stored.
  logic [XLEN-1:0] mem [NREGS-1:1];

  // ---------------------------------------------------------------- sweep FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == SWEEP) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(NREGS - 1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign run       = (state_q == RUN);
  assign wr_en_run = run ? bus.wr_en : '0;
  assign iss_run   = run & bus.iss_valid;
  assign bus.ready = run;

  // ------------------------------------------------------------------- array
  // NOTE: the storage array has no reset; clearing it is the sweep's job, which
  // keeps it mappable onto plain RAM/flop arrays without a reset tree.
  // Ports are applied in ascending order, so the highest colliding port's
  // assignment is the one that lands.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_run[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
          mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // -------------------------------------------------------------- read muxes
  always_comb begin
    rd_data_c = '0;
    rd_a      = '0;
    rd_word   = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_a    = bus.rd_addr[i*AW +: AW];
      rd_word = '0;
      if (run && (rd_a != '0)) begin
        rd_word = mem[rd_a];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en_run[j] && (bus.wr_addr[j*AW +: AW] == rd_a)) begin
              rd_word = bus.wr_data[j*XLEN +: XLEN];
            end
          end
        end
      end
      rd_data_c[i*XLEN +: XLEN] = rd_word;
    end
  end

  assign bus.rd_data = rd_data_c;

  // --------------------------------------------------------------- scoreboard
  regfile_sb #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (iss_run),
    .iss_rd_i    (bus.iss_rd),
    .wr_en_i     (wr_en_run),
    .wr_addr_i   (bus.wr_addr),
    .rd_addr_i   (bus.rd_addr),
    .rd_busy_o   (sb_busy)
  );

  assign bus.rd_busy = run ? sb_busy : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Drives two register files (BYPASS=1 and BYPASS=0, otherwise identical:
// 32 x 32-bit, 4 read ports, 2 write ports) with the same stimulus.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 4;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rfa ();
  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rfb ();

  assign rfa.rd_addr = rd_addr;   assign rfb.rd_addr = rd_addr;
  assign rfa.wr_en = wr_en;       assign rfb.wr_en = wr_en;
  assign rfa.wr_addr = wr_addr;   assign rfb.wr_addr = wr_addr;
  assign rfa.wr_data = wr_data;   assign rfb.wr_data = wr_data;
  assign rfa.iss_valid = iss_valid; assign rfb.iss_valid = iss_valid;
  assign rfa.iss_rd = iss_rd;     assign rfb.iss_rd = iss_rd;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(rfa.slave)
  );
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .bus(rfb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic set_all_rd(input logic [AW-1:0] a);
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] dat(input int inst, input int port);
    return (inst == 0) ? rfa.rd_data[port*XLEN +: XLEN] : rfb.rd_data[port*XLEN +: XLEN];
  endfunction

  // One cycle of directed stimulus: ports 2/3 read the same register as port 0.
  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            iv;
    logic [AW-1:0]   ir;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] d0_b, d0_n;
    logic            busy_b, busy_n;
    logic [XLEN-1:0] d1_b;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  // Reference model for the random phase.
  logic [XLEN-1:0] m_mem [NREGS];
  logic            m_busy [NREGS];

  // Sweep phase: ready low for 31 edges then high; reads 0 and not busy
  // throughout; write to x5 / issue of x6 attempted the whole time.
  task automatic sweep_phase(input string tag, input logic [AW-1:0] ra);
    for (int e = 1; e <= NREGS - 1; e++) begin
      @(posedge clk); #1;
      check({tag, "_ready_b"}, 64'(rfa.ready), 64'(e == NREGS - 1));
      check({tag, "_ready_n"}, 64'(rfb.ready), 64'(e == NREGS - 1));
      if (e < NREGS - 1) begin
        check({tag, "_sweep_rd"}, 64'(dat(0, 0)), 64'h0);
        check({tag, "_sweep_busy"}, 64'(rfa.rd_busy), 64'h0);
      end
    end
    idle();
    set_all_rd(ra);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_all_rd(5'd5);
    #12;
    check("rst_ready_b", 64'(rfa.ready), 64'h0);
    check("rst_ready_n", 64'(rfb.ready), 64'h0);
    check("rst_busy", 64'(rfa.rd_busy), 64'h0);

    // ---------------- test 1: sweep with writes/issues that must be ignored
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: XLEN] = 32'h5555_5555;
    iss_valid = 1'b1; iss_rd = 5'd6;
    sweep_phase("init", 5'd5);
    #1;
    for (int r = 0; r < NREGS; r++) begin
      set_all_rd(AW'(r)); #1;
      for (int p = 0; p < NRD; p++) check("post_sweep_zero", 64'(dat(0, p)), 64'h0);
      check("post_sweep_zero_n", 64'(dat(1, 0)), 64'h0);
    end
    set_all_rd(5'd6); #1;
    check("x6_not_busy", 64'(rfa.rd_busy), 64'h0);

    // ---------------- tests 2-4 plus setup of test 5: directed vectors
    //                 we     wa0    wa1    wd0           wd1           iv    ir     ra0    ra1     d0_b          d0_n          bb    bn    d1_b
    vecs[0]  = '{2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{2'b01, 5'd0, 5'd0, 32'h1234,     32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{2'b11, 5'd7, 5'd7, 32'h11,       32'h22,       1'b0, 5'd0, 5'd7, 5'd3, 32'h22,       32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd7, 5'd3, 32'h22,       32'h22,       1'b0, 1'b0, 32'hDEADBEEF};
    vecs[6]  = '{2'b11, 5'd7, 5'd8, 32'h33,       32'h44,       1'b0, 5'd0, 5'd7, 5'd8, 32'h33,       32'h22,       1'b0, 1'b0, 32'h44};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd7, 5'd8, 32'h33,       32'h33,       1'b0, 1'b0, 32'h44};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
    vecs[10] = '{2'b01, 5'd9, 5'd0, 32'h99,       32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h99,       32'h0,        1'b0, 1'b1, 32'h0};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h99,       32'h99,       1'b0, 1'b0, 32'h0};
    vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h99,       32'h99,       1'b0, 1'b0, 32'h0};
    vecs[13] = '{2'b01, 5'd9, 5'd0, 32'hAA,       32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'hAA,       32'h99,       1'b0, 1'b1, 32'h0};
    vecs[14] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'hAA,       32'hAA,       1'b1, 1'b1, 32'h0};
    vecs[15] = '{2'b10, 5'd0, 5'd9, 32'h0,        32'hBB,       1'b0, 5'd0, 5'd9, 5'd0, 32'hBB,       32'hAA,       1'b0, 1'b1, 32'h0};
    vecs[16] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'hBB,       32'hBB,       1'b0, 1'b0, 32'h0};
    vecs[17] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h0,        1'b0, 1'b0, 32'hBB};
    vecs[18] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h0,        1'b0, 1'b0, 32'hBB};
    vecs[19] = '{2'b01, 5'd4, 5'd0, 32'hA5A5A5A5, 32'h0,        1'b1, 5'd4, 5'd4, 5'd9, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 32'hBB};
    vecs[20] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd4, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hBB};

    for (int v = 0; v < NV; v++) begin
      wr_en = vecs[v].we;
      wr_addr = {vecs[v].wa1, vecs[v].wa0};
      wr_data = {vecs[v].wd1, vecs[v].wd0};
      iss_valid = vecs[v].iv;
      iss_rd = vecs[v].ir;
      rd_addr = {vecs[v].ra0, vecs[v].ra0, vecs[v].ra1, vecs[v].ra0};
      #1;
      check($sformatf("vec%0d_d0_b", v), 64'(dat(0, 0)), 64'(vecs[v].d0_b));
      check($sformatf("vec%0d_d2_b", v), 64'(dat(0, 2)), 64'(vecs[v].d0_b));
      check($sformatf("vec%0d_d3_b", v), 64'(dat(0, 3)), 64'(vecs[v].d0_b));
      check($sformatf("vec%0d_d1_b", v), 64'(dat(0, 1)), 64'(vecs[v].d1_b));
      check($sformatf("vec%0d_d0_n", v), 64'(dat(1, 0)), 64'(vecs[v].d0_n));
      check($sformatf("vec%0d_busy_b", v), 64'(rfa.rd_busy[0]), 64'(vecs[v].busy_b));
      check($sformatf("vec%0d_busy_n", v), 64'(rfb.rd_busy[0]), 64'(vecs[v].busy_n));
      @(posedge clk); #1;
    end

    // ---------------- test 5: reset mid-run with x4 = A5A5A5A5 busy
    idle();
    set_all_rd(5'd4); #1;
    check("pre_rst_busy_x4", 64'(rfa.rd_busy[0]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready_b", 64'(rfa.ready), 64'h0);
    check("midrst_ready_n", 64'(rfb.ready), 64'h0);
    check("midrst_busy_b", 64'(rfa.rd_busy), 64'h0);
    check("midrst_busy_n", 64'(rfb.rd_busy), 64'h0);
    check("midrst_rd_b", 64'(dat(0, 0)), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_phase("resweep", 5'd4);
    #1;
    check("resweep_x4_b", 64'(dat(0, 0)), 64'h0);
    check("resweep_x4_n", 64'(dat(1, 0)), 64'h0);
    check("resweep_x4_busy", 64'(rfa.rd_busy[0]), 64'h0);

    // ---------------- test 6: random traffic on a narrow address window
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      logic [XLEN-1:0] eb, en;
      logic            bb, bn;
      logic [AW-1:0]   a, wa;
      wr_en = 2'($urandom_range(0, 3));
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = AW'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < NRD; i++) begin
        a = rd_addr[i*AW +: AW];
        en = (a == 0) ? '0 : m_mem[a];
        bn = (a == 0) ? 1'b0 : m_busy[a];
        eb = en;
        bb = bn;
        for (int j = NWR - 1; j >= 0; j--) begin
          if (a != 0 && wr_en[j] && wr_addr[j*AW +: AW] == a) begin
            eb = wr_data[j*XLEN +: XLEN];
            bb = 1'b0;
            break;
          end
        end
        check($sformatf("rnd%0d_p%0d_d_b", c, i), 64'(dat(0, i)), 64'(eb));
        check($sformatf("rnd%0d_p%0d_d_n", c, i), 64'(dat(1, i)), 64'(en));
        check($sformatf("rnd%0d_p%0d_busy_b", c, i), 64'(rfa.rd_busy[i]), 64'(bb));
        check($sformatf("rnd%0d_p%0d_busy_n", c, i), 64'(rfb.rd_busy[i]), 64'(bn));
      end
      for (int j = 0; j < NWR; j++) begin
        wa = wr_addr[j*AW +: AW];
        if (wr_en[j] && wa != 0) begin
          m_mem[wa] = wr_data[j*XLEN +: XLEN];
          m_busy[wa] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
